// File: rtl/regfile_sb.sv
// Decode-stage register file: two async read ports, two sync write ports, optional
// write-to-read bypass, and a per-register busy scoreboard with issue handshake.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int BYPASS     = 1,
  parameter int DBG_REG    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] wa0,
  input  logic [DATA_WIDTH-1:0] wd0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] wa1,
  input  logic [DATA_WIDTH-1:0] wd1,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  output logic                  iss_ready,
  output logic [ADDR_WIDTH:0]   busy_cnt,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic [ADDR_WIDTH:0]   r_cnt;

  logic                  w_wr0;
  logic                  w_wr1;
  logic                  w_wr0_eff;
  logic [NUM_REGS-1:0]   w_clr;
  logic                  w_set;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic [ADDR_WIDTH:0]   w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_ad   [2];
  logic [DATA_WIDTH-1:0] w_rd   [2];
  logic                  w_bsy  [2];

  assign w_wr0 = we0 && (wa0 != '0);
  assign w_wr1 = we1 && (wa1 != '0);
  // Load port wins a same-address collision, so the ALU write is suppressed.
  assign w_wr0_eff = w_wr0 && !(w_wr1 && (wa1 == wa0));

  always_comb begin
    w_clr = '0;
    if (w_wr0) w_clr[wa0] = 1'b1;
    if (w_wr1) w_clr[wa1] = 1'b1;
  end

  assign iss_ready = iss_valid &&
                     ((iss_addr == '0) || !r_busy[iss_addr] || w_clr[iss_addr]);
  assign w_set     = iss_ready && (iss_addr != '0);

  // NOTE: always_comb outputs get a default before any conditional update, so no latch is inferred.
  always_comb begin
    w_busy_nxt = r_busy & ~w_clr;
    if (w_set) w_busy_nxt[iss_addr] = 1'b1;
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + (ADDR_WIDTH+1)'(w_busy_nxt[i]);
    end
  end

  // NOTE: the register array is in the async reset because the architectural state must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_wr0_eff) r_regs[wa0] <= wd0;
      if (w_wr1)     r_regs[wa1] <= wd1;
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign w_ad[0] = AD1;
  assign w_ad[1] = AD2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p]  = r_regs[w_ad[p]];
      w_bsy[p] = r_busy[w_ad[p]];
      if (BYPASS != 0) begin
        if (w_wr1 && (wa1 == w_ad[p])) begin
          w_rd[p]  = wd1;
          w_bsy[p] = 1'b0;
        end else if (w_wr0 && (wa0 == w_ad[p])) begin
          w_rd[p]  = wd0;
          w_bsy[p] = 1'b0;
        end
      end
      if (w_ad[p] == '0) begin
        w_rd[p]  = '0;
        w_bsy[p] = 1'b0;
      end
    end
  end

  assign RD1      = w_rd[0];
  assign RD2      = w_rd[1];
  assign busy1    = w_bsy[0];
  assign busy2    = w_bsy[1];
  assign busy_cnt = r_cnt;

  generate
    if (DBG_REG == 0) begin : g_dbg_zero
      assign dbg_data = '0;
    end else begin : g_dbg_tap
      assign dbg_data = r_regs[DBG_REG];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance share
// all inputs; expected values are hand-computed constants.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  AD1 = '0, AD2 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_addr = '0;

  logic [31:0] b_rd1, b_rd2, b_dbg, n_rd1, n_rd2, n_dbg;
  logic        b_busy1, b_busy2, b_rdy, n_busy1, n_busy2, n_rdy;
  logic [5:0]  b_cnt, n_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .AD1(AD1), .AD2(AD2), .RD1(b_rd1), .RD2(b_rd2),
    .busy1(b_busy1), .busy2(b_busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(b_rdy), .busy_cnt(b_cnt), .dbg_data(b_dbg)
  );

  regfile_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .AD1(AD1), .AD2(AD2), .RD1(n_rd1), .RD2(n_rd2),
    .busy1(n_busy1), .busy2(n_busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(n_rdy), .busy_cnt(n_cnt), .dbg_data(n_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    AD1 = 5'd5; AD2 = 5'd6;
    #1;
    check("rst_rd1", b_rd1, 32'h0);
    check("rst_cnt", {26'h0, b_cnt}, 32'd0);
    check("rst_rdy", {31'h0, b_rdy}, 32'd0);
    #4 rst_n = 1'b1;
    step();

    // x0 write and issue are both harmless
    AD1 = 5'd0; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    #1;
    check("x0_rd1_byp", b_rd1, 32'h0);
    check("x0_busy1", {31'h0, b_busy1}, 32'd0);
    check("x0_iss_ready", {31'h0, b_rdy}, 32'd1);
    step(); idle();
    check("x0_rd1_after", b_rd1, 32'h0);
    check("x0_cnt", {26'h0, b_cnt}, 32'd0);

    // Bypass vs no bypass on x7
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_AAAA;
    step(); idle();
    AD1 = 5'd7; we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_1234;
    #1;
    check("byp_rd1_same", b_rd1, 32'h0000_1234);
    check("nob_rd1_same", n_rd1, 32'h0000_AAAA);
    step(); idle();
    check("nob_rd1_next", n_rd1, 32'h0000_1234);

    // Collision on x9: load port wins
    AD2 = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h22;
    #1;
    check("coll_byp_same", b_rd2, 32'h22);
    step(); idle();
    check("coll_byp_next", b_rd2, 32'h22);
    check("coll_nob_next", n_rd2, 32'h22);

    // Scoreboard on x3
    AD1 = 5'd3;
    iss_valid = 1'b1; iss_addr = 5'd3;
    #1;
    check("sb_iss_ready1", {31'h0, b_rdy}, 32'd1);
    step();
    check("sb_busy1", {31'h0, b_busy1}, 32'd1);
    check("sb_cnt1", {26'h0, b_cnt}, 32'd1);
    check("sb_iss_blocked", {31'h0, b_rdy}, 32'd0);
    step();
    check("sb_cnt_hold", {26'h0, n_cnt}, 32'd1);
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h33;
    #1;
    check("sb_iss_wr_ready", {31'h0, n_rdy}, 32'd1);
    check("sb_byp_busy_clear", {31'h0, b_busy1}, 32'd0);
    check("sb_nob_busy_still", {31'h0, n_busy1}, 32'd1);
    step(); idle();
    check("sb_busy_reset_by_iss", {31'h0, n_busy1}, 32'd1);
    check("sb_cnt_after", {26'h0, b_cnt}, 32'd1);
    check("sb_rd_x3", n_rd1, 32'h33);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h3;
    step(); idle();
    check("sb_cnt_clear", {26'h0, b_cnt}, 32'd0);
    check("sb_busy_clear", {31'h0, n_busy1}, 32'd0);

    // Fill the scoreboard, then write everything back
    for (int r = 1; r < 32; r++) begin
      iss_valid = 1'b1; iss_addr = 5'(r);
      #1;
      check($sformatf("fill_rdy_%0d", r), {31'h0, b_rdy}, 32'd1);
      step();
    end
    idle();
    check("fill_cnt_byp", {26'h0, b_cnt}, 32'd31);
    check("fill_cnt_nob", {26'h0, n_cnt}, 32'd31);
    iss_valid = 1'b1; iss_addr = 5'd17;
    #1;
    check("fill_iss_full", {31'h0, b_rdy}, 32'd0);
    step(); idle();
    check("fill_cnt_nowrap", {26'h0, b_cnt}, 32'd31);
    for (int r = 1; r < 32; r++) begin
      if (r % 2 == 1) begin
        we1 = 1'b1; wa1 = 5'(r); wd1 = 32'h100 + 32'(r);
      end else begin
        we0 = 1'b1; wa0 = 5'(r); wd0 = 32'h100 + 32'(r);
      end
      step(); idle();
      if (r == 16) check("drain_cnt_half", {26'h0, b_cnt}, 32'd15);
    end
    check("drain_cnt_byp", {26'h0, b_cnt}, 32'd0);
    check("drain_cnt_nob", {26'h0, n_cnt}, 32'd0);
    check("dbg_byp", b_dbg, 32'h10A);
    check("dbg_nob", n_dbg, 32'h10A);

    // Reset asserted mid-cycle clears state immediately
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEAD;
    step(); idle();
    iss_valid = 1'b1; iss_addr = 5'd6;
    step(); idle();
    AD1 = 5'd5; AD2 = 5'd6;
    #1;
    check("pre_rst_rd5", n_rd1, 32'hDEAD);
    check("pre_rst_busy6", {31'h0, n_busy2}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rd5", n_rd1, 32'h0);
    check("mid_rst_busy6", {31'h0, b_busy2}, 32'd0);
    check("mid_rst_cnt", {26'h0, b_cnt}, 32'd0);
    check("mid_rst_dbg", b_dbg, 32'h0);
    #4 rst_n = 1'b1;
    step();
    check("post_rst_rd5", b_rd1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
